// File: rtl/ram_mp.sv
// ram_mp: multi-port node memory with one write port and READ_PORTS
// independent read ports.
//
// After reset the memory can zero itself: the CLEAR state writes 0 to
// every word before init_done rises. Reads and writes then proceed in the
// same cycle. Read latency (1 or 2) and same-address read-during-write
// behaviour (old data or bypassed new data) are set by parameters.
//
// Ports:
//   clock     system clock, all state changes on the rising edge
//   reset     synchronous reset, active-low
//   init_done high once the memory is usable
//   wr_en     write strobe
//   wr_addr   write address
//   wr_data   write data
//   rd_en     per-port read strobe
//   rd_addr   packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid  per-port one-cycle data-valid pulse
//   addr_err  sticky flag, set by any out-of-range access while ready
module ram_mp #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 11,
    parameter int DEPTH          = 2048,
    parameter int READ_PORTS     = 2,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             init_done,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [READ_PORTS-1:0]            rd_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_valid,
    output logic                             addr_err
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [0:0] ST_AFTER_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Source selection for the first read stage output
    localparam logic [1:0] SEL_ZERO = 2'd0;   // out-of-range read, or nothing read yet
    localparam logic [1:0] SEL_MEM  = 2'd1;   // registered array read
    localparam logic [1:0] SEL_BYP  = 2'd2;   // same-cycle write data

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    logic [0:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clear_ptr_reg, clear_ptr_next;
    logic                  init_done_reg, init_done_next;
    logic                  addr_err_reg, addr_err_next;

    logic                  ready;
    logic                  clearing;
    logic                  wr_in_range;
    logic                  wr_ok;
    logic [READ_PORTS-1:0] rd_in_range;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign ready       = (state_reg == ST_READY);
    assign clearing    = (state_reg == ST_CLEAR);
    assign wr_in_range = (32'(wr_addr) < DEPTH);
    assign wr_ok       = ready && wr_en && wr_in_range;

    // ------------------------------------------------------------------
    // Control: clear sequence, init flag, sticky address error
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        clear_ptr_next = clear_ptr_reg;
        init_done_next = init_done_reg;
        addr_err_next  = addr_err_reg;
        case (state_reg)
            ST_CLEAR: begin
                clear_ptr_next = clear_ptr_reg + 1'b1;
                if (clear_ptr_reg == LAST_ADDR) begin
                    state_next     = ST_READY;
                    init_done_next = 1'b1;
                end
            end
            default: begin
                init_done_next = 1'b1;
                if ((wr_en && !wr_in_range) || ((rd_en & ~rd_in_range) != '0)) begin
                    addr_err_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= ST_AFTER_RESET;
            clear_ptr_reg <= '0;
            init_done_reg <= 1'b0;
            addr_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clear_ptr_reg <= clear_ptr_next;
            init_done_reg <= init_done_next;
            addr_err_reg  <= addr_err_next;
        end
    end

    assign init_done = init_done_reg;
    assign addr_err  = addr_err_reg;

    // ------------------------------------------------------------------
    // Single write port, shared between the zero-fill and user writes.
    // Contents are never reset so the array maps onto block RAM.
    // ------------------------------------------------------------------
    assign mem_we    = reset && (clearing || wr_ok);
    assign mem_waddr = clearing ? clear_ptr_reg : wr_addr;
    assign mem_wdata = clearing ? '0 : wr_data;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_reg[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] addr;
            logic                  fire;
            logic                  hit;
            logic [DATA_WIDTH-1:0] byp_q;
            logic [DATA_WIDTH-1:0] mem_q_reg;
            logic [1:0]            sel_reg, sel_next;
            logic                  valid1_reg;
            logic [DATA_WIDTH-1:0] stage1_data;

            assign addr            = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign fire            = reset && ready && rd_en[gi];
            assign rd_in_range[gi] = (32'(addr) < DEPTH);

            // Plain registered read; read-before-write ordering comes for
            // free because the write lands in the array on the same edge.
            always_ff @(posedge clock) begin
                if (fire) begin
                    mem_q_reg <= mem_reg[addr];
                end
            end

            if (RDW_MODE == 1) begin : g_byp
                logic [DATA_WIDTH-1:0] byp_reg;
                // wr_ok already implies the address is in range
                assign hit = wr_ok && (wr_addr == addr);
                always_ff @(posedge clock) begin
                    if (fire && hit) begin
                        byp_reg <= wr_data;
                    end
                end
                assign byp_q = byp_reg;
            end else begin : g_nobyp
                assign hit   = 1'b0;
                assign byp_q = '0;
            end

            always_comb begin
                sel_next = SEL_MEM;
                if (!rd_in_range[gi]) begin
                    sel_next = SEL_ZERO;
                end else if (hit) begin
                    sel_next = SEL_BYP;
                end
            end

            // sel_reg only moves on a request, so the output holds its
            // last value between pulses; reset selects zero.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    valid1_reg <= 1'b0;
                    sel_reg    <= SEL_ZERO;
                end else begin
                    valid1_reg <= fire;
                    if (fire) begin
                        sel_reg <= sel_next;
                    end
                end
            end

            always_comb begin
                case (sel_reg)
                    SEL_MEM: stage1_data = mem_q_reg;
                    SEL_BYP: stage1_data = byp_q;
                    default: stage1_data = '0;
                endcase
            end

            if (READ_LATENCY == 2) begin : g_lat2
                logic [DATA_WIDTH-1:0] data2_reg;
                logic                  valid2_reg;
                always_ff @(posedge clock) begin
                    if (!reset) begin
                        data2_reg  <= '0;
                        valid2_reg <= 1'b0;
                    end else begin
                        valid2_reg <= valid1_reg;
                        if (valid1_reg) begin
                            data2_reg <= stage1_data;
                        end
                    end
                end
                assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data2_reg;
                assign rd_valid[gi]                         = valid2_reg;
            end else begin : g_lat1
                assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = stage1_data;
                assign rd_valid[gi]                         = valid1_reg;
            end
        end
    endgenerate

endmodule
